mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory-access and write-back stage of the multi-cycle CPU, directly downstream of the execute ALU. It accepts one executed instruction at a time: opcode, ALU result, effective/branch address, branch flag and PC. It then performs the data-memory load or store, resolves the next PC, and drives the register-file write-back. It owns the word-addressed data memory.

## Interface
- `DEPTH`, 256: data-memory words; power of two, at least 4.
- `RD_LAT`, 1: load read latency in cycles, range 1..4.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: execute stage presents an instruction.
- `in_ready` output 1: stage can accept; high only in IDLE.
- `op` input 6: opcode, ir[31:26].
- `alu_i` input 32: ALU result. For R-type this is the write-back value; for SW it is the store data.
- `addr_i` input 32: byte address. Effective address for LW/SW; target for BEQ/JMP.
- `ife_i` input 1: branch-taken flag, used only for BEQ.
- `pc_i` input 32: PC of the instruction.
- `rd_i` input 5: destination register index.
- `reg_update` output 1: register write-enable, one-cycle pulse.
- `reg_wdata` output 32: write-back data.
- `rd_o` output 5: write-back register index.
- `pc_o` output 32: next PC.
- `pc_load` output 1: one-cycle pulse; `pc_o` is valid.
- `done` output 1: one-cycle pulse; instruction retired.
- `misalign_err` output 1: sticky misaligned-access flag.

## Operation
- FSM states: IDLE, ACCESS, WAIT, WB.
- IDLE: `in_ready`=1. On `in_valid`, latch op, alu_i, addr_i, ife_i, pc_i and rd_i.
  - LW (010001) and SW (010000) go to ACCESS.
  - Every other op goes to WB.
- ACCESS:
  - SW writes `mem[addr[AW+1:2]]` ← alu, where AW=log2(DEPTH).
  - LW issues the read.
  - If RD_LAT=1, go to WB; otherwise go to WAIT.
- WAIT: a counter runs RD_LAT-1 cycles, then goes to WB. Load data is captured on the final cycle.
- WB (one cycle), then return to IDLE:
  - R-type (000000–000101): `reg_update`=1, `reg_wdata`=alu.
  - LW: `reg_update`=1, `reg_wdata`=loaded word.
  - SW, BEQ, JMP and undefined ops: `reg_update`=0.
  - JMP (100001): `pc_o`=addr.
  - BEQ (100000): `pc_o`=addr if the latched ife=1, else pc+4.
  - All other ops: `pc_o`=pc+4.
  - PC arithmetic is 32-bit modulo 2^32.
  - `pc_load`=1 and `done`=1 in all cases.
- Undefined opcodes retire as a NOP with pc+4.
- Address bits above AW+1 are ignored: the memory index wraps modulo DEPTH.
- Memory contents are not reset.

## Timing
- Reset values, all applied immediately on `rst_n` low:
  - `in_ready`=1 once in IDLE.
  - `reg_update`, `pc_load`, `done`, `misalign_err` = 0.
  - `reg_wdata`, `pc_o` = 0; `rd_o`=0.
  - FSM in IDLE; WAIT counter cleared.
- Latency from the accepting edge to `done`:
  - R-type, BEQ, JMP, NOP: 2 cycles.
  - SW: 3 cycles.
  - LW: 2+RD_LAT cycles.
- `in_ready` drops the cycle after acceptance and returns high the cycle after WB. There is no back-to-back acceptance.
- Input changes while not in IDLE are ignored; only latched values are used.
- `reg_wdata`, `rd_o` and `pc_o` hold their values after WB until the next WB.
- Reset asserted mid-operation:
  - The FSM aborts to IDLE with no `reg_update` or `done`.
  - A SW aborted before its ACCESS edge does not write memory.
- A SW then a LW to the same address: the LW returns the stored value, since the write completes before the next accept.

## Configuration
- `MEM_WB_ALIGN_CHECK_EN` defined:
  - A LW/SW with addr[1:0]≠0 performs no memory access and no `reg_update`.
  - It still retires with pc+4 and sets `misalign_err`=1.
  - `misalign_err` is sticky until reset.
- `MEM_WB_ALIGN_CHECK_EN` undefined:
  - addr[1:0] is ignored and the access is word-aligned.
  - `misalign_err` is tied to 0.

## Test plan
- Reset, then ADD with alu_i=0x0000_0007, rd_i=3, pc_i=0x100 -> 2 cycles later `reg_update`=1, `reg_wdata`=7, `rd_o`=3, `pc_o`=0x104, `done`=1, all in one pulse.
- SW alu_i=0xDEADBEEF addr_i=0x10, then LW addr_i=0x10 rd_i=5 with RD_LAT=3 -> SW `done` at +3 with `reg_update`=0; LW `done` at +5 with `reg_wdata`=0xDEADBEEF.
- BEQ addr_i=0x200, pc_i=0x40: with ife_i=1 -> `pc_o`=0x200; with ife_i=0 -> `pc_o`=0x44. JMP addr_i=0x80 -> `pc_o`=0x80.
- PC wrap: NOP at pc_i=0xFFFF_FFFC -> `pc_o`=0. LW addr_i=4*DEPTH+8 -> reads word index 2.
- `rst_n` pulsed low during LW WAIT -> no `done`, `in_ready`=1, and all outputs 0 immediately.
- With `MEM_WB_ALIGN_CHECK_EN`: SW addr_i=0x13 -> memory unchanged, `misalign_err`=1 and held, `pc_o`=pc+4.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: data-memory load/store, next-PC resolution, register write-back.
// Optional misaligned-access detection is enabled with `define MEM_WB_ALIGN_CHECK_EN.
module mem_wb_stage #(
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  op,
    input  logic [31:0] alu_i,
    input  logic [31:0] addr_i,
    input  logic        ife_i,
    input  logic [31:0] pc_i,
    input  logic [4:0]  rd_i,
    output logic        reg_update,
    output logic [31:0] reg_wdata,
    output logic [4:0]  rd_o,
    output logic [31:0] pc_o,
    output logic        pc_load,
    output logic        done,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] WAIT_LAST = 3'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    localparam logic [5:0] OP_RMAX = 6'h05;
    localparam logic [5:0] OP_SW   = 6'h10;
    localparam logic [5:0] OP_LW   = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h20;
    localparam logic [5:0] OP_JMP  = 6'h21;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_WB} state_t;

    state_t      state, next_state;
    logic [5:0]  op_q;
    logic [31:0] alu_q, addr_q, pc_q, load_data;
    logic        ife_q;
    logic [4:0]  rd_q;
    logic [2:0]  wait_cnt;
    logic [31:0] mem [DEPTH];

    logic [AW-1:0] idx;
    logic          is_lw, is_sw, is_rtype, misalign, wait_last;
    logic [31:0]   next_pc;

    assign idx       = addr_q[AW+1:2];
    assign is_lw     = (op_q == OP_LW);
    assign is_sw     = (op_q == OP_SW);
    assign is_rtype  = (op_q <= OP_RMAX);
    assign wait_last = (wait_cnt == WAIT_LAST);
    assign in_ready  = (state == S_IDLE);

`ifdef MEM_WB_ALIGN_CHECK_EN
    assign misalign = (is_lw || is_sw) && (addr_q[1:0] != 2'b00);
`else
    logic unused_addr_bits;
    assign misalign         = 1'b0;
    assign unused_addr_bits = ^addr_q[1:0];
`endif

    always_comb begin
        next_pc = pc_q + 32'd4;
        if (op_q == OP_JMP || (op_q == OP_BEQ && ife_q))
            next_pc = addr_q;
    end

    // NOTE: next-state logic gets its default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:   if (in_valid) next_state = (op == OP_LW || op == OP_SW) ? S_ACCESS : S_WB;
            S_ACCESS: next_state = (RD_LAT == 1 || !is_lw || misalign) ? S_WB : S_WAIT;
            S_WAIT:   if (wait_last) next_state = S_WB;
            S_WB:     next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            op_q     <= '0;
            alu_q    <= '0;
            addr_q   <= '0;
            ife_q    <= 1'b0;
            pc_q     <= '0;
            rd_q     <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == S_WAIT) ? wait_cnt + 3'd1 : 3'd0;
            if (state == S_IDLE && in_valid) begin
                op_q   <= op;
                alu_q  <= alu_i;
                addr_q <= addr_i;
                ife_q  <= ife_i;
                pc_q   <= pc_i;
                rd_q   <= rd_i;
            end
        end
    end

    // NOTE: the data memory has no reset; clearing it would turn the array into flops instead of RAM.
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && is_sw && !misalign)
            mem[idx] <= alu_q;
    end

    // Load data lands on the last cycle of the read latency window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            load_data <= '0;
        else if ((state == S_ACCESS && RD_LAT == 1) || (state == S_WAIT && wait_last))
            load_data <= mem[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_update <= 1'b0;
            pc_load    <= 1'b0;
            done       <= 1'b0;
            reg_wdata  <= '0;
            rd_o       <= '0;
            pc_o       <= '0;
        end else begin
            reg_update <= 1'b0;
            pc_load    <= 1'b0;
            done       <= 1'b0;
            if (state == S_WB) begin
                reg_update <= is_rtype || (is_lw && !misalign);
                reg_wdata  <= is_lw ? load_data : alu_q;
                rd_o       <= rd_q;
                pc_o       <= next_pc;
                pc_load    <= 1'b1;
                done       <= 1'b1;
            end
        end
    end

`ifdef MEM_WB_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_err <= 1'b0;
        else if (state == S_WB && misalign)
            misalign_err <= 1'b1;
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (DEPTH=256, RD_LAT=3).
module tb_mem_wb_stage;

    localparam int DEPTH  = 256;
    localparam int RD_LAT = 3;

    logic        clk, rst_n, in_valid, in_ready, ife_i;
    logic [5:0]  op;
    logic [31:0] alu_i, addr_i, pc_i, reg_wdata, pc_o;
    logic [4:0]  rd_i, rd_o;
    logic        reg_update, pc_load, done, misalign_err;

    int total = 0;
    int bad   = 0;

    mem_wb_stage #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .alu_i(alu_i), .addr_i(addr_i), .ife_i(ife_i), .pc_i(pc_i), .rd_i(rd_i),
        .reg_update(reg_update), .reg_wdata(reg_wdata), .rd_o(rd_o), .pc_o(pc_o),
        .pc_load(pc_load), .done(done), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of one issued instruction, sampled on falling edges.
    int          r_lat;
    logic        r_ru, r_pl, r_dn_next, r_rdy1, r_rdy_done;
    logic [31:0] r_wd, r_po;
    logic [4:0]  r_ro;

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] ad,
                         input logic f, input logic [31:0] p, input logic [4:0] r);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        op = o; alu_i = a; addr_i = ad; ife_i = f; pc_i = p; rd_i = r; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 6'h3f; alu_i = ~a; addr_i = ~ad; ife_i = ~f; pc_i = ~p; rd_i = ~r;
        r_lat = 0; r_rdy1 = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) r_rdy1 = in_ready;
            if (done) begin r_lat = k; break; end
        end
        r_ru = reg_update; r_wd = reg_wdata; r_ro = rd_o; r_po = pc_o; r_pl = pc_load;
        r_rdy_done = in_ready;
        @(negedge clk);
        r_dn_next = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; alu_i = '0; addr_i = '0; ife_i = 1'b0; pc_i = '0; rd_i = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, reg_update, pc_load, done, misalign_err, reg_wdata, pc_o, rd_o} !== {1'b1, 4'b0, 69'b0}) begin
            bad++;
            $display("FAIL reset_state: rdy=%b ru=%b pl=%b dn=%b me=%b wd=%h pc=%h rd=%0d expected rdy=1, rest 0",
                     in_ready, reg_update, pc_load, done, misalign_err, reg_wdata, pc_o, rd_o);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rtype;
        issue(6'h00, 32'h0000_0007, 32'h0, 1'b0, 32'h100, 5'd3);
        total++;
        if ({r_lat, r_ru, r_wd, r_ro, r_po, r_pl} !== {32'd2, 1'b1, 32'd7, 5'd3, 32'h104, 1'b1}) begin
            bad++;
            $display("FAIL add: lat=%0d ru=%b wd=%h rd=%0d pc=%h pl=%b expected lat=2 ru=1 wd=7 rd=3 pc=104 pl=1",
                     r_lat, r_ru, r_wd, r_ro, r_po, r_pl);
        end
        total++;
        if ({r_rdy1, r_rdy_done, r_dn_next} !== 3'b010) begin
            bad++;
            $display("FAIL add_handshake: rdy_after_accept=%b rdy_at_done=%b done_next=%b expected 0 1 0",
                     r_rdy1, r_rdy_done, r_dn_next);
        end
        issue(6'h05, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h200, 5'd31);
        total++;
        if ({r_lat, r_ru, r_wd, r_ro, r_po} !== {32'd2, 1'b1, 32'hFFFF_FFFF, 5'd31, 32'h204}) begin
            bad++;
            $display("FAIL rtype5: lat=%0d ru=%b wd=%h rd=%0d pc=%h expected lat=2 ru=1 wd=ffffffff rd=31 pc=204",
                     r_lat, r_ru, r_wd, r_ro, r_po);
        end
    endtask

    task automatic test_sw_lw;
        issue(6'h10, 32'hDEAD_BEEF, 32'h10, 1'b0, 32'h300, 5'd9);
        total++;
        if ({r_lat, r_ru, r_po} !== {32'd3, 1'b0, 32'h304}) begin
            bad++;
            $display("FAIL sw: lat=%0d ru=%b pc=%h expected lat=3 ru=0 pc=304", r_lat, r_ru, r_po);
        end
        issue(6'h11, 32'h0, 32'h10, 1'b0, 32'h304, 5'd5);
        total++;
        if ({r_lat, r_ru, r_wd, r_ro, r_po} !== {32'd5, 1'b1, 32'hDEAD_BEEF, 5'd5, 32'h308}) begin
            bad++;
            $display("FAIL lw: lat=%0d ru=%b wd=%h rd=%0d pc=%h expected lat=5 ru=1 wd=deadbeef rd=5 pc=308",
                     r_lat, r_ru, r_wd, r_ro, r_po);
        end
    endtask

    task automatic test_branch_jump;
        issue(6'h20, 32'h0, 32'h200, 1'b1, 32'h40, 5'd1);
        total++;
        if ({r_lat, r_ru, r_po} !== {32'd2, 1'b0, 32'h200}) begin
            bad++;
            $display("FAIL beq_taken: lat=%0d ru=%b pc=%h expected lat=2 ru=0 pc=200", r_lat, r_ru, r_po);
        end
        issue(6'h20, 32'h0, 32'h200, 1'b0, 32'h40, 5'd1);
        total++;
        if ({r_ru, r_po} !== {1'b0, 32'h44}) begin
            bad++;
            $display("FAIL beq_not_taken: ru=%b pc=%h expected ru=0 pc=44", r_ru, r_po);
        end
        issue(6'h21, 32'h0, 32'h80, 1'b0, 32'h40, 5'd1);
        total++;
        if ({r_lat, r_ru, r_po} !== {32'd2, 1'b0, 32'h80}) begin
            bad++;
            $display("FAIL jmp: lat=%0d ru=%b pc=%h expected lat=2 ru=0 pc=80", r_lat, r_ru, r_po);
        end
    endtask

    task automatic test_wrap_and_nop;
        issue(6'h3E, 32'h1234, 32'h0, 1'b1, 32'hFFFF_FFFC, 5'd4);
        total++;
        if ({r_lat, r_ru, r_po, r_pl} !== {32'd2, 1'b0, 32'h0, 1'b1}) begin
            bad++;
            $display("FAIL nop_pc_wrap: lat=%0d ru=%b pc=%h pl=%b expected lat=2 ru=0 pc=0 pl=1", r_lat, r_ru, r_po, r_pl);
        end
        issue(6'h10, 32'h1234_5678, 32'h8, 1'b0, 32'h500, 5'd0);
        issue(6'h11, 32'h0, 32'(4 * DEPTH + 8), 1'b0, 32'h504, 5'd6);
        total++;
        if ({r_ru, r_wd, r_ro} !== {1'b1, 32'h1234_5678, 5'd6}) begin
            bad++;
            $display("FAIL lw_index_wrap: ru=%b wd=%h rd=%0d expected ru=1 wd=12345678 rd=6", r_ru, r_wd, r_ro);
        end
    endtask

    task automatic test_reset_mid_op;
        int seen = 0;
        @(negedge clk);
        op = 6'h11; alu_i = '0; addr_i = 32'h10; ife_i = 1'b0; pc_i = 32'h600; rd_i = 5'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({in_ready, reg_update, pc_load, done, reg_wdata, pc_o, rd_o} !== {1'b1, 3'b0, 69'b0}) begin
            bad++;
            $display("FAIL reset_in_wait: rdy=%b ru=%b pl=%b dn=%b wd=%h pc=%h rd=%0d expected rdy=1, rest 0",
                     in_ready, reg_update, pc_load, done, reg_wdata, pc_o, rd_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin @(negedge clk); if (done || reg_update) seen++; end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL reset_abort_no_retire: pulses=%0d expected 0", seen);
        end
    endtask

    task automatic test_abort_sw;
        @(negedge clk);
        op = 6'h10; alu_i = 32'hBAD0_BAD0; addr_i = 32'h10; ife_i = 1'b0; pc_i = 32'h700; rd_i = 5'd0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(6'h11, 32'h0, 32'h10, 1'b0, 32'h704, 5'd8);
        total++;
        if ({r_ru, r_wd} !== {1'b1, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL aborted_sw_no_write: ru=%b wd=%h expected ru=1 wd=deadbeef", r_ru, r_wd);
        end
    endtask

    task automatic test_align;
`ifdef MEM_WB_ALIGN_CHECK_EN
        issue(6'h10, 32'h5555_5555, 32'h13, 1'b0, 32'h800, 5'd0);
        total++;
        if ({r_ru, r_po, misalign_err} !== {1'b0, 32'h804, 1'b1}) begin
            bad++;
            $display("FAIL misaligned_sw: ru=%b pc=%h err=%b expected ru=0 pc=804 err=1", r_ru, r_po, misalign_err);
        end
        issue(6'h11, 32'h0, 32'h10, 1'b0, 32'h804, 5'd2);
        total++;
        if ({r_ru, r_wd, misalign_err} !== {1'b1, 32'hDEAD_BEEF, 1'b1}) begin
            bad++;
            $display("FAIL misaligned_sticky: ru=%b wd=%h err=%b expected ru=1 wd=deadbeef err=1", r_ru, r_wd, misalign_err);
        end
`else
        issue(6'h10, 32'hCAFE_F00D, 32'h13, 1'b0, 32'h800, 5'd0);
        issue(6'h11, 32'h0, 32'h10, 1'b0, 32'h804, 5'd2);
        total++;
        if ({r_ru, r_wd, misalign_err} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            bad++;
            $display("FAIL unaligned_word_access: ru=%b wd=%h err=%b expected ru=1 wd=cafef00d err=0", r_ru, r_wd, misalign_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_sw_lw();
        test_branch_jump();
        test_wrap_and_nop();
        test_reset_mid_op();
        test_abort_sw();
        test_align();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
